dma_axi_wr_drain: RTL and testbench
===================================

Name: dma_axi_wr_drain

Overview:
AXI4 write-master back end of the DMA channel. It drains the channel data FIFO (read side: rd_en/data_out/rd_ack/empty) and converts a (destination address, beat count) job into one or more AXI4 INCR write bursts. It sits between the data FIFO and the AXI4 AW/W/B channels, and is started by the DMA channel controller.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; equals FIFO_WIDTH; power of 2, 8..1024
LEN_WIDTH, 16, width of job length in beats
MAX_BURST, 16, maximum beats per burst, 1..256

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start pulse; ignored unless busy=0
dst_addr  in  ADDR_WIDTH  job byte address, sampled on accepted start; must be DATA_WIDTH/8 aligned
num_beats  in  LEN_WIDTH  job length in beats, sampled on start; 0 = no-op
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
error  out  1  any BRESP!=OKAY in last job; sticky until next accepted start
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request
fifo_data  in  DATA_WIDTH  FIFO data_out
fifo_rd_ack  in  1  FIFO read acknowledge; data valid this cycle
awaddr  out  ADDR_WIDTH  burst start address
awlen  out  8  beats-1
awsize  out  3  log2(DATA_WIDTH/8), constant
awburst  out  2  2'b01 INCR, constant
awvalid  out  1
awready  in  1
wdata  out  DATA_WIDTH
wstrb  out  DATA_WIDTH/8  all ones
wlast  out  1
wvalid  out  1
wready  in  1
bresp  in  2
bvalid  in  1
bready  out  1

Behaviour:
- Reset, async: state=IDLE; busy, done, error, fifo_rd_en, awvalid, wvalid, wlast, bready = 0; awaddr, awlen, wdata = 0.
- States: IDLE, AW, FETCH, WAIT_D, WDATA, BRESP, FIN.
- IDLE: on start with num_beats!=0: latch addr and remaining=num_beats; clear error; busy=1; go to AW next cycle. start with num_beats=0: done pulses the next cycle, busy stays 0, error cleared. start while busy=1 is ignored.
- Burst sizing (computed on entry to AW): blen = min(remaining, MAX_BURST, beats to next 4KB boundary). Beats to boundary = (4096 - addr[11:0]) / (DATA_WIDTH/8). awlen = blen-1.
- AW: awvalid=1 with awaddr/awlen held stable until awready is sampled high. Next state is FETCH. awvalid never drops without a handshake.
- FETCH: if fifo_empty=0, fifo_rd_en=1 for exactly one cycle, then go to WAIT_D. If fifo_empty=1, stay in FETCH with rd_en=0 (no timeout).
- WAIT_D: on fifo_rd_ack, capture fifo_data into wdata and go to WDATA. Only one pop is outstanding at a time.
- WDATA: wvalid=1, wdata stable, wlast=1 on the blen-th beat of the burst. On wready: decrement beat counter. If beats remain, go to FETCH; otherwise go to BRESP.
- The W burst never starts before its AW is accepted (AW precedes FETCH).
- BRESP: bready=1. On bvalid, error |= (bresp!=2'b00). Then addr += blen*DATA_WIDTH/8 and remaining -= blen. If remaining!=0, go to AW; else go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Minimum per-beat cost is 3 cycles plus wready wait (FETCH, WAIT_D, WDATA).
- Reset mid-job aborts immediately to IDLE. No AXI recovery is attempted; the interconnect is reset together with this block.
- Address wraps modulo 2^ADDR_WIDTH. LEN_WIDTH arithmetic does not overflow.

Test Plan:
- Single burst: dst_addr=0x1000, num_beats=4, FIFO holds A0..A3, awready/wready always 1 -> one AW (awaddr=0x1000, awlen=3, awsize=2, awburst=1); wdata A0..A3; wlast on 4th beat only; bready until bvalid; done pulses once; error=0.
- Split by MAX_BURST: num_beats=40, addr=0x0 -> three bursts with awlen 15, 15, 7 at awaddr 0x0, 0x40, 0x80; 40 pops total.
- 4KB boundary: addr=0x0FF8, num_beats=6 -> burst 1 at 0xFF8 with awlen=1, burst 2 at 0x1000 with awlen=3.
- Backpressure and starvation: awready held low 5 cycles, wready toggling, FIFO empty for 10 cycles mid-burst -> awvalid, wvalid and wdata stable while stalled; no pop while fifo_empty=1; data order preserved.
- Error response: 2-burst job, first bresp=SLVERR (2'b10) -> second burst still issued; done pulses; error=1 after done; error cleared on next start.
- Corner cases: num_beats=0 -> done the next cycle with no AXI activity. rst_n asserted during WDATA -> all outputs at reset values immediately, busy=0.

Source files
------------

// File: rtl/dma_axi_wr_drain.sv
// AXI4 write-master back end of a DMA channel. It pops the channel data FIFO one beat at a time
// and splits a (address, beat count) job into INCR bursts that never cross a 4KB boundary.
module dma_axi_wr_drain #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    num_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_data,
    input  logic                    fifo_rd_ack,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {
        StIdle, StAw, StFetch, StWaitD, StWdata, StBresp, StFin
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [7:0]              awlen_q, awlen_d;
    logic [8:0]              beat_q, beat_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    error_q, error_d;
    logic [8:0]              blen;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [LEN_WIDTH-1:0]    nxt_rem;
    logic [7:0]              nxt_len;
    logic [7:0]              start_len;

    // Burst length minus one: limited by remaining beats, MAX_BURST and the next 4KB boundary.
    function automatic logic [7:0] burst_len(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [LEN_WIDTH-1:0] r);
        int unsigned room;
        int unsigned n;
        room = (32'd4096 - 32'(a[11:0])) / BYTES;
        n    = 32'(r);
        if (n > MAX_BURST) n = MAX_BURST;
        if (n > room) n = room;
        return 8'(n - 32'd1);
    endfunction

    always_comb begin
        blen      = {1'b0, awlen_q} + 9'd1;
        nxt_addr  = addr_q + ADDR_WIDTH'(32'(blen) * BYTES);
        nxt_rem   = rem_q - LEN_WIDTH'(blen);
        nxt_len   = burst_len(nxt_addr, nxt_rem);
        start_len = burst_len(dst_addr, num_beats);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        awlen_d    = awlen_q;
        beat_d     = beat_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        busy       = 1'b0;
        done       = 1'b0;
        fifo_rd_en = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_beats != '0) begin
                        addr_d  = dst_addr;
                        rem_d   = num_beats;
                        awlen_d = start_len;
                        beat_d  = {1'b0, start_len} + 9'd1;
                        state_d = StAw;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StAw: begin
                busy    = 1'b1;
                awvalid = 1'b1;
                if (awready) state_d = StFetch;
            end
            StFetch: begin
                busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = StWaitD;
                end
            end
            StWaitD: begin
                busy = 1'b1;
                if (fifo_rd_ack) begin
                    wdata_d = fifo_data;
                    state_d = StWdata;
                end
            end
            StWdata: begin
                busy   = 1'b1;
                wvalid = 1'b1;
                wlast  = (beat_q == 9'd1);
                if (wready) begin
                    beat_d  = beat_q - 9'd1;
                    state_d = (beat_q == 9'd1) ? StBresp : StFetch;
                end
            end
            StBresp: begin
                busy   = 1'b1;
                bready = 1'b1;
                if (bvalid) begin
                    if (bresp != 2'b00) error_d = 1'b1;
                    addr_d = nxt_addr;
                    rem_d  = nxt_rem;
                    if (nxt_rem != '0) begin
                        awlen_d = nxt_len;
                        beat_d  = {1'b0, nxt_len} + 9'd1;
                        state_d = StAw;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            awlen_q <= '0;
            beat_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            awlen_q <= awlen_d;
            beat_q  <= beat_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    assign awaddr  = addr_q;
    assign awlen   = awlen_q;
    assign awsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign wdata   = wdata_q;
    assign wstrb   = '1;
    assign error   = error_q;

endmodule

// File: tb/tb_dma_axi_wr_drain.sv
// Directed bench for dma_axi_wr_drain: job-level burst/data model plus per-cycle protocol checks.
module tb_dma_axi_wr_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic [15:0] num_beats = '0;
    logic        busy, done, error;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_ack = 1'b0;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    always #5 clk = ~clk;

    dma_axi_wr_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dst_addr(dst_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .error(error), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_rd_ack(fifo_rd_ack),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment state and the job-level model.
    logic [31:0] fq[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_aw_addr[$];
    int          exp_aw_len[$];
    int          exp_wlen[$];
    logic [31:0] aw_log_addr[$];
    int          aw_log_len[$];
    logic [1:0]  bplan[$];
    bit          starve = 0;
    int          aw_stall = 0;
    int          w_mode = 0;
    bit          err_exp = 0;
    int          aw_beats = 0, w_beats = 0, w_idx = 0, pops = 0, wlast_cnt = 0;
    int          done_cnt = 0, done_base = 0, b_cnt = 0, aw_stall_seen = 0;
    bit          p_aw_stall = 0, p_w_stall = 0, p_wlast = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0;
    logic [7:0]  p_awlen = '0;

    // FIFO: pop accepted on rd_en && !empty, data presented with ack on the following cycle.
    always @(posedge clk) begin : fifo_model
        logic pop;
        pop = fifo_rd_en && !fifo_empty;
        #1;
        if (pop && fq.size() > 0) begin
            fifo_data   = fq.pop_front();
            fifo_rd_ack = 1'b1;
        end else begin
            fifo_data   = 32'hDEAD_BEEF;
            fifo_rd_ack = 1'b0;
        end
        fifo_empty = starve || (fq.size() == 0);
    end

    always @(posedge clk) begin : aw_slave
        logic v;
        v = awvalid;
        #1;
        if (v && aw_stall > 0) aw_stall--;
        awready = (aw_stall == 0);
    end

    always @(posedge clk) begin : w_slave
        #1;
        case (w_mode)
            1:       wready = ~wready;
            2:       wready = 1'b0;
            default: wready = 1'b1;
        endcase
    end

    always @(posedge clk) begin : b_slave
        logic r, v;
        r = bready;
        v = bvalid;
        #1;
        if (r && v) begin
            bvalid = 1'b0;
            if (bplan.size() > 0) void'(bplan.pop_front());
        end else if (r) begin
            bvalid = 1'b1;
            bresp  = (bplan.size() > 0) ? bplan[0] : 2'b00;
        end
    end

    // Per-cycle compare against the model and AXI stability rules.
    always @(negedge clk) begin : monitor
        logic [31:0] ed;
        bit          el;
        if (!rst_n) begin
            p_aw_stall = 0;
            p_w_stall  = 0;
        end else begin
            if (p_aw_stall) begin
                chk("aw_hold_valid", 64'(awvalid), 64'd1);
                chk("aw_hold_addr", 64'(awaddr), 64'(p_awaddr));
                chk("aw_hold_len", 64'(awlen), 64'(p_awlen));
            end
            if (awvalid && !awready) aw_stall_seen++;
            if (awvalid && awready) begin
                if (exp_aw_addr.size() == 0) begin
                    chk("aw_unexpected", 64'(exp_aw_addr.size()), 64'd1);
                end else begin
                    chk("awaddr", 64'(awaddr), 64'(exp_aw_addr.pop_front()));
                    chk("awlen", 64'(awlen), 64'(exp_aw_len.pop_front()));
                    chk("awsize", 64'(awsize), 64'd2);
                    chk("awburst", 64'(awburst), 64'd1);
                end
                aw_log_addr.push_back(awaddr);
                aw_log_len.push_back(int'(awlen));
                aw_beats += int'(awlen) + 1;
            end
            p_aw_stall = awvalid && !awready;
            p_awaddr   = awaddr;
            p_awlen    = awlen;

            if (p_w_stall) begin
                chk("w_hold_valid", 64'(wvalid), 64'd1);
                chk("w_hold_data", 64'(wdata), 64'(p_wdata));
                chk("w_hold_last", 64'(wlast), 64'(p_wlast));
            end
            if (wvalid && wready) begin
                chk("w_after_aw", 64'(w_beats < aw_beats), 64'd1);
                chk("wstrb", 64'(wstrb), 64'hF);
                if (exp_data.size() == 0) begin
                    chk("w_extra_beat", 64'(exp_data.size()), 64'd1);
                end else begin
                    ed = exp_data.pop_front();
                    chk("wdata", 64'(wdata), 64'(ed));
                end
                el = (exp_wlen.size() > 0) && (w_idx == exp_wlen[0]);
                chk("wlast", 64'(wlast), 64'(el));
                if (el) begin
                    void'(exp_wlen.pop_front());
                    w_idx = 0;
                end else begin
                    w_idx++;
                end
                if (wlast) wlast_cnt++;
                w_beats++;
            end
            p_w_stall = wvalid && !wready;
            p_wdata   = wdata;
            p_wlast   = wlast;

            if (fifo_empty && fifo_rd_en) chk("pop_while_empty", 64'(fifo_rd_en), 64'd0);
            if (fifo_rd_en && !fifo_empty) pops++;
            if (bvalid && bready) begin
                b_cnt++;
                if (bresp != 2'b00) err_exp = 1;
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", 64'(busy), 64'd0);
                chk("done_aw_left", 64'(exp_aw_addr.size()), 64'd0);
                chk("done_data_left", 64'(exp_data.size()), 64'd0);
                chk("done_error", 64'(error), 64'(err_exp));
            end
        end
    end

    // Expected bursts: each is min(remaining, 16, beats to the next 4KB page).
    task automatic plan_job(input logic [31:0] a, input int n);
        int          rem = n;
        logic [31:0] ad = a;
        while (rem > 0) begin
            int room = (4096 - int'(ad % 32'd4096)) / 4;
            int b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_aw_addr.push_back(ad);
            exp_aw_len.push_back(b - 1);
            exp_wlen.push_back(b - 1);
            ad  = ad + 32'(b * 4);
            rem = rem - b;
        end
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 32'(i));
            exp_data.push_back(base + 32'(i));
        end
    endtask

    task automatic pulse_start(input logic [31:0] a, input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        dst_addr  = a;
        num_beats = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic start_job(input logic [31:0] a, input int n);
        plan_job(a, n);
        err_exp = 0;
        aw_log_addr.delete();
        aw_log_len.delete();
        aw_beats = 0; w_beats = 0; w_idx = 0; pops = 0; wlast_cnt = 0; b_cnt = 0;
        aw_stall_seen = 0;
        done_base = done_cnt;
        pulse_start(a, n);
    endtask

    task automatic end_job(input string tag);
        int cyc = 0;
        while (done_cnt == done_base && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (done_cnt == done_base) chk({tag, "_timeout"}, 64'(done_cnt - done_base), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_awvalid"}, 64'(awvalid), 64'd0);
        chk({tag, "_wvalid"}, 64'(wvalid), 64'd0);
        chk({tag, "_wlast"}, 64'(wlast), 64'd0);
        chk({tag, "_bready"}, 64'(bready), 64'd0);
        chk({tag, "_awaddr"}, 64'(awaddr), 64'd0);
        chk({tag, "_awlen"}, 64'(awlen), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check_reset("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 4-beat burst.
        load(32'hA0, 4);
        @(negedge clk);
        start_job(32'h1000, 4);
        @(negedge clk);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        end_job("t1");
        chk("t1_aw_count", 64'(aw_log_addr.size()), 64'd1);
        chk("t1_awaddr", 64'(aw_log_addr[0]), 64'h1000);
        chk("t1_awlen", 64'(aw_log_len[0]), 64'd3);
        chk("t1_beats", 64'(w_beats), 64'd4);
        chk("t1_wlast_count", 64'(wlast_cnt), 64'd1);
        chk("t1_b_count", 64'(b_cnt), 64'd1);
        chk("t1_error", 64'(error), 64'd0);

        // 40 beats split by the burst limit; a second start while busy is ignored.
        load(32'h1_0000, 40);
        @(negedge clk);
        start_job(32'h0, 40);
        repeat (3) @(negedge clk);
        pulse_start(32'h9000, 5);
        end_job("t2");
        chk("t2_aw_count", 64'(aw_log_addr.size()), 64'd3);
        chk("t2_len0", 64'(aw_log_len[0]), 64'd15);
        chk("t2_len1", 64'(aw_log_len[1]), 64'd15);
        chk("t2_len2", 64'(aw_log_len[2]), 64'd7);
        chk("t2_addr1", 64'(aw_log_addr[1]), 64'h40);
        chk("t2_addr2", 64'(aw_log_addr[2]), 64'h80);
        chk("t2_pops", 64'(pops), 64'd40);

        // 4KB boundary split.
        load(32'h2_0000, 6);
        @(negedge clk);
        start_job(32'h0FF8, 6);
        end_job("t3");
        chk("t3_aw_count", 64'(aw_log_addr.size()), 64'd2);
        chk("t3_addr0", 64'(aw_log_addr[0]), 64'hFF8);
        chk("t3_len0", 64'(aw_log_len[0]), 64'd1);
        chk("t3_addr1", 64'(aw_log_addr[1]), 64'h1000);
        chk("t3_len1", 64'(aw_log_len[1]), 64'd3);

        // Backpressure on AW and W, FIFO starved mid-burst.
        load(32'h3_0000, 8);
        @(negedge clk);
        aw_stall = 5;
        w_mode   = 1;
        start_job(32'h2000, 8);
        cyc = 0;
        while (w_beats < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_reached_beat3", 64'(w_beats >= 3), 64'd1);
        starve = 1;
        repeat (10) @(negedge clk);
        starve = 0;
        end_job("t4");
        w_mode = 0;
        chk("t4_aw_stall_cycles", 64'(aw_stall_seen >= 5), 64'd1);
        chk("t4_awlen", 64'(aw_log_len[0]), 64'd7);
        chk("t4_beats", 64'(w_beats), 64'd8);

        // SLVERR on first of two bursts; error sticky until next start.
        load(32'h4_0000, 20);
        bplan.push_back(2'b10);
        bplan.push_back(2'b00);
        @(negedge clk);
        start_job(32'h3000, 20);
        end_job("t5");
        chk("t5_aw_count", 64'(aw_log_addr.size()), 64'd2);
        chk("t5_b_count", 64'(b_cnt), 64'd2);
        repeat (3) @(negedge clk);
        chk("t5_error_sticky", 64'(error), 64'd1);

        // Zero-length job: done next cycle, no AXI activity, error cleared.
        start_job(32'h5000, 0);
        @(negedge clk);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_error_cleared", 64'(error), 64'd0);
        end_job("t6");
        chk("t6_no_aw", 64'(aw_log_addr.size()), 64'd0);
        chk("t6_no_pops", 64'(pops), 64'd0);

        // Reset while a W beat is stalled.
        load(32'h5_0000, 4);
        w_mode = 2;
        @(negedge clk);
        start_job(32'h4000, 4);
        cyc = 0;
        while (!wvalid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t7_reached_wdata", 64'(wvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid");
        fq.delete();
        exp_data.delete();
        exp_aw_addr.delete();
        exp_aw_len.delete();
        exp_wlen.delete();
        w_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t7_idle_busy", 64'(busy), 64'd0);
        chk("t7_idle_awvalid", 64'(awvalid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
